// File: rtl/rvv_backend_lsu_mapinfo_fifo_pkg.sv
// Shared types for the LSU map-info FIFO: lane count and the per-uop map record.
package rvv_backend_lsu_mapinfo_fifo_pkg;

  localparam int NUM_LSU = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rob_entry;
    logic [2:0] uop_index;
    logic       is_load;
  } LSU_MAP_INFO_t;

endpackage

// File: rtl/rvv_backend_lsu_mapinfo_fifo_multi_fifo.sv
// Generic N-in/N-out FIFO. In-order contiguous push/pop, count-based flags registered
// from the next count, combinational head read of N slots.
module rvv_backend_lsu_mapinfo_fifo_multi_fifo #(
  parameter type T          = logic [7:0],
  parameter int  DEPTH      = 8,
  parameter int  N          = 2,
  localparam int DW_PTR     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [N-1:0]      push,
  input  T     [N-1:0]      datain,
  output logic              full,
  output logic [N-1:0]      almost_full,
  input  logic [N-1:0]      pop,
  output T     [N-1:0]      dataout,
  output logic              empty,
  output logic [N-1:0]      almost_empty,
  output logic [DW_PTR:0]   count
);

  T                  mem [DEPTH];
  logic [DW_PTR-1:0] wptr_q, rptr_q;
  logic [DW_PTR:0]   count_q, count_d, npush, npop, free_d;
  logic [N-1:0]      push_eff, pop_eff, ae_q, af_q, ae_d, af_d;

  // Only the contiguous low run counts; the flag masks keep it within capacity.
  always_comb begin
    logic prun, orun;
    prun     = 1'b1;
    orun     = 1'b1;
    push_eff = '0;
    pop_eff  = '0;
    npush    = '0;
    npop     = '0;
    for (int i = 0; i < N; i++) begin
      prun        = prun & push[i];
      orun        = orun & pop[i];
      push_eff[i] = prun & ~af_q[i];
      pop_eff[i]  = orun & ~ae_q[i];
      npush       = npush + {{DW_PTR{1'b0}}, push_eff[i]};
      npop        = npop  + {{DW_PTR{1'b0}}, pop_eff[i]};
    end
    count_d = flush ? '0 : count_q + npush - npop;
    free_d  = (DW_PTR+1)'(DEPTH) - count_d;
    for (int i = 0; i < N; i++) begin
      ae_d[i] = count_d <= (DW_PTR+1)'(i);
      af_d[i] = free_d  <= (DW_PTR+1)'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ae_q    <= '1;
      af_q    <= '0;
    end else begin
      wptr_q  <= flush ? '0 : wptr_q + DW_PTR'(npush);
      rptr_q  <= flush ? '0 : rptr_q + DW_PTR'(npop);
      count_q <= count_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
    end
  end

  // Storage is deliberately unreset; reads are qualified by almost_empty.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < N; i++)
        if (push_eff[i]) mem[DW_PTR'(wptr_q + DW_PTR'(i))] <= datain[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      dataout[i] = mem[DW_PTR'(rptr_q + DW_PTR'(i))];
  end

  assign count        = count_q;
  assign empty        = ae_q[0];
  assign almost_empty = ae_q;
  assign full         = af_q[0];
  assign almost_full  = af_q;

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= (DW_PTR+1)'(DEPTH));
  a_empty_match: assert property (@(posedge clk) disable iff (!rst_n)
    ae_q[0] == (count_q == '0));

`ifdef RVV_BACKEND_SVA
  // Protocol checks on the producer/consumer side; define RVV_BACKEND_SVA to enable.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n || flush) (push & af_q) == '0);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n || flush) (pop & ae_q) == '0);
  a_push_contig:  assert property (@(posedge clk) disable iff (!rst_n) (push & N'(push + 1'b1)) == '0);
  a_pop_contig:   assert property (@(posedge clk) disable iff (!rst_n) (pop & N'(pop + 1'b1)) == '0);
`endif

endmodule

// File: rtl/rvv_backend_lsu_mapinfo_fifo.sv
// LSU map-info FIFO: dispatch pushes up to NUM_LSU records per cycle, remap reads and pops the head in order.
module rvv_backend_lsu_mapinfo_fifo
  import rvv_backend_lsu_mapinfo_fifo_pkg::*;
#(
  parameter int  DEPTH  = 8,
  localparam int DW_PTR = $clog2(DEPTH),
  localparam int N      = NUM_LSU
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic          [N-1:0]   push,
  input  LSU_MAP_INFO_t [N-1:0]   datain,
  output logic                    full,
  output logic          [N-1:0]   almost_full,
  input  logic          [N-1:0]   pop,
  output LSU_MAP_INFO_t [N-1:0]   dataout,
  output logic                    empty,
  output logic          [N-1:0]   almost_empty,
  output logic          [DW_PTR:0] count
);

  rvv_backend_lsu_mapinfo_fifo_multi_fifo #(
    .T     (LSU_MAP_INFO_t),
    .DEPTH (DEPTH),
    .N     (N)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .datain       (datain),
    .full         (full),
    .almost_full  (almost_full),
    .pop          (pop),
    .dataout      (dataout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count)
  );

endmodule
